// File: rtl/side_stream_descrambler_gen_pkg.sv
// Shared constants, types and scrambler-term helpers
// for the 1000BASE-T receive PCS.
package pcs_rx_pkg;
  localparam int LFSR_W     = 33;
  localparam int TAP_MASTER = 13;
  localparam int TAP_SLAVE  = 20;
  localparam int SC_W       = 8;
  localparam int SDN_W      = 9;

  typedef logic [LFSR_W-1:0] scr_t;

  function automatic logic [3:0] sy_f(input scr_t s);
    return {s[9] ^ s[14] ^ s[19] ^ s[24],
            s[6] ^ s[16],
            s[3] ^ s[8],
            s[0]};
  endfunction

  function automatic logic [3:0] sx_f(input scr_t s);
    return {s[13] ^ s[15] ^ s[18] ^ s[20] ^
            s[23] ^ s[25] ^ s[28] ^ s[30],
            s[10] ^ s[12] ^ s[20] ^ s[22],
            s[7] ^ s[9] ^ s[12] ^ s[14],
            s[4] ^ s[6]};
  endfunction

  function automatic logic [3:0] sg_f(input scr_t s);
    return {s[4] ^ s[8],
            s[3] ^ s[7],
            s[2] ^ s[6],
            s[1] ^ s[5]};
  endfunction
endpackage

// File: rtl/side_stream_descrambler_gen_if.sv
// Symbol-side bundle between the receive PCS control
// and the scrambler-word generator.
interface side_stream_descrambler_gen_if;
  import pcs_rx_pkg::*;

  logic              io_advance;
  logic              io_load;
  scr_t              io_seed;
  logic              io_tx_enable;
  logic              io_loc_rcvr_status;
  logic [SC_W-1:0]   io_scn;
  logic              io_tx_enable_d2;
  logic              io_scn_valid;
  logic              io_lfsr_err;

  modport master (
    output io_advance, io_load, io_seed,
    output io_tx_enable, io_loc_rcvr_status,
    input  io_scn, io_tx_enable_d2,
    input  io_scn_valid, io_lfsr_err
  );

  modport slave (
    input  io_advance, io_load, io_seed,
    input  io_tx_enable, io_loc_rcvr_status,
    output io_scn, io_tx_enable_d2,
    output io_scn_valid, io_lfsr_err
  );
endinterface

// File: rtl/side_stream_descrambler_gen_lfsr.sv
// 33-bit side-stream LFSR with load and all-zero guard.
// Load has priority over stepping.
import pcs_rx_pkg::*;

module ss_lfsr33 #(
  parameter bit   MASTER = 1'b1,
  parameter scr_t SEED   = 33'h1_FFFF_FFFF
) (
  input  logic clock,
  input  logic reset,
  input  logic advance,
  input  logic load,
  input  scr_t seed,
  output scr_t scr,
  output logic err
);
  localparam int TAP = MASTER ? TAP_MASTER : TAP_SLAVE;

  logic nb;

  assign nb = scr[TAP-1] ^ scr[LFSR_W-1];

  // A zero state would lock the LFSR, so it is forced to 1 and flagged
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scr <= SEED;
      err <= 1'b0;
    end else if (load) begin
      if (seed == '0) begin
        scr <= scr_t'(1);
        err <= 1'b1;
      end else begin
        scr <= seed;
      end
    end else if (scr == '0) begin
      scr <= scr_t'(1);
      err <= 1'b1;
    end else if (advance) begin
      scr <= {scr[LFSR_W-2:0], nb};
    end
  end
endmodule

// File: rtl/side_stream_descrambler_gen.sv
// Receive-side Sc_n generator: LFSR, tx_enable
// alignment and Sc_n selection for the Descrambler.
import pcs_rx_pkg::*;

module side_stream_descrambler_gen #(
  parameter bit   MASTER = 1'b1,
  parameter scr_t SEED   = 33'h1_FFFF_FFFF
) (
  input logic clock,
  input logic reset,
  side_stream_descrambler_gen_if.slave bus
);
  scr_t            scr;
  logic            lfsr_err;
  logic            te_d1;
  logic            te_d2;
  logic [SC_W-1:0] sc;
  logic [SC_W-1:0] scn;
  logic            te_out;
  logic            scn_valid;
  logic [3:0]      sy;
  logic [3:0]      sx;
  logic [3:0]      sg;

  ss_lfsr33 #(
    .MASTER (MASTER),
    .SEED   (SEED)
  ) u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .advance (bus.io_advance),
    .load    (bus.io_load),
    .seed    (bus.io_seed),
    .scr     (scr),
    .err     (lfsr_err)
  );

  always_comb begin
    sy = sy_f(scr);
    sx = sx_f(scr);
    sg = sg_f(scr);
    sc = '0;
    if (te_d2) begin
      sc = {sy, sx};
    end else begin
      sc = {4'b0000, sg[3:1],
            sx[0] ^ ~bus.io_loc_rcvr_status};
    end
  end

  // Sc_n uses the pre-step state so it lines up with Sd_n
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      te_d1     <= 1'b0;
      te_d2     <= 1'b0;
      scn       <= '0;
      te_out    <= 1'b0;
      scn_valid <= 1'b0;
    end else begin
      scn_valid <= bus.io_advance;
      if (bus.io_load) begin
        te_d1 <= 1'b0;
        te_d2 <= 1'b0;
      end else if (bus.io_advance) begin
        te_d1  <= bus.io_tx_enable;
        te_d2  <= te_d1;
        scn    <= sc;
        te_out <= te_d2;
      end
    end
  end

  assign bus.io_scn          = scn;
  assign bus.io_tx_enable_d2 = te_out;
  assign bus.io_scn_valid    = scn_valid;
  assign bus.io_lfsr_err     = lfsr_err;
endmodule

// File: doc/side_stream_descrambler_gen.md
Name: side_stream_descrambler_gen

Overview:
- Receive-side side-stream scrambler-word generator for the 1000BASE-T PCS.
- Runs a 33-bit LFSR once per symbol period and derives the 8-bit scrambler word Sc_n (io_scn) consumed by the Descrambler stage directly downstream.
- Applies the tx_enable-dependent Sc_n selection rules and the 2-symbol tx_enable alignment, so the Descrambler receives an io_scn already aligned with io_sdn.

Parameters:
- MASTER, default 1, 1 selects g_M(x)=1+x^13+x^33; 0 selects g_S(x)=1+x^20+x^33.
- SEED, default 33'h1_FFFF_FFFF, LFSR value after reset. Must be non-zero.

Ports:
- clock  in  1  symbol-rate clock (125 MHz).
- reset  in  1  asynchronous, active-high.
- io_advance  in  1  symbol strobe; LFSR and pipeline step only when 1.
- io_load  in  1  synchronous load of io_seed into the LFSR.
- io_seed  in  33  load value.
- io_tx_enable  in  1  receive-side tx_enable estimate for symbol n.
- io_loc_rcvr_status  in  1  local receiver status (1=OK).
- io_scn  out  8  Sc_n[7:0] to Descrambler.
- io_tx_enable_d2  out  1  tx_enable_{n-2}, aligned with io_scn.
- io_scn_valid  out  1  high in cycles where io_scn is fresh (registered io_advance).
- io_lfsr_err  out  1  sticky; LFSR was found or loaded all-zero.

Behaviour:
- Reset (async assert, sync release) sets: LFSR=SEED; te_d1=te_d2=0; io_scn=0; io_tx_enable_d2=0; io_scn_valid=0; io_lfsr_err=0.
- LFSR step, scr[32:0], applied when io_advance=1:
  - MASTER: new bit = scr[12]^scr[32].
  - Slave: new bit = scr[19]^scr[32].
  - Shift: scr <= {scr[31:0], new}.
- Priority: io_load over io_advance.
  - On io_load: LFSR <= io_seed, and te_d1/te_d2 clear to 0.
  - If io_seed==0: LFSR <= 33'h1 and io_lfsr_err sets.
- io_lfsr_err sets whenever LFSR==0 is detected. It clears only on reset.
- Derived terms, combinational from the current scr:
  - Sy[0]=scr[0]; Sy[1]=scr[3]^scr[8]; Sy[2]=scr[6]^scr[16]; Sy[3]=scr[9]^scr[14]^scr[19]^scr[24].
  - Sx[0]=scr[4]^scr[6]; Sx[1]=scr[7]^scr[9]^scr[12]^scr[14]; Sx[2]=scr[10]^scr[12]^scr[20]^scr[22]; Sx[3]=scr[13]^scr[15]^scr[18]^scr[20]^scr[23]^scr[25]^scr[28]^scr[30].
  - Sg[0]=scr[1]^scr[5]; Sg[1]=scr[2]^scr[6]; Sg[2]=scr[3]^scr[7]; Sg[3]=scr[4]^scr[8].
- Sc selection, where te2 = te_d2:
  - Sc[7:4] = te2 ? Sy[3:0] : 4'b0.
  - Sc[3:1] = te2 ? Sx[3:1] : Sg[3:1].
  - Sc[0] = Sx[0] ^ (te2 ? 1'b0 : ~io_loc_rcvr_status).
- Pipeline on io_advance:
  - te_d1 <= io_tx_enable; te_d2 <= te_d1.
  - io_scn <= Sc computed from pre-step scr and pre-shift te_d2.
  - io_tx_enable_d2 <= te_d2.
- Latency: exactly 1 clock from io_advance to io_scn update. io_scn_valid = io_advance delayed 1 clock.
- io_advance=0 holds all state and outputs, except io_scn_valid, which drops.
- Simultaneous io_load and io_advance: load wins; no step occurs.
- Reset asserted mid-stream: immediate return to reset values. The first io_scn after release is derived from SEED.

Decomposition:
- Shared package pcs_rx_pkg:
  - constants LFSR_W=33, TAP_MASTER=13, TAP_SLAVE=20, SC_W=8, SDN_W=9.
  - typedef scr_t logic[32:0].
  - functions sy_f, sx_f, sg_f (scr_t -> logic[3:0]).
- One sub-module: ss_lfsr33 (LFSR register, step/load, zero guard).
- The top level holds the tx_enable pipeline and the Sc mux.

Test Plan:
1. Reset, MASTER=1, SEED default, io_advance=1 for 40 clocks, tx_enable=0, loc_rcvr_status=1 -> io_scn[7:4]=0 every cycle. LFSR sequence matches the reference model step new=scr[12]^scr[32]. io_scn_valid=1 from cycle 2.
2. Slave, io_load seed 33'h0000_0001 then advance 33 clocks -> LFSR equals the model value. Sy[0] sequence equals the golden bit stream.
3. tx_enable 0→1 at symbol k -> Sc[7:4] switches to Sy exactly at io_scn of symbol k+2. io_tx_enable_d2 rises in the same cycle.
4. tx_enable=0, loc_rcvr_status toggled -> io_scn[0] flips relative to Sx[0]. With te2=1 there is no effect.
5. io_load with io_seed=0 -> LFSR=1 and io_lfsr_err=1 persist until reset. Simultaneous io_load+io_advance -> no step.
6. io_advance gapped (1 of 4 cycles) and reset asserted mid-stream -> outputs hold between strobes. Async reset clears outputs without a clock edge.
